// File: rtl/dhm_pd_pkg.sv
// Shared types and defaults for the dhm power-domain switch controller.
// Counter width helper sizes the single down-counter for the longest wait.
package dhm_pd_pkg;

    typedef enum logic [3:0] {
        ST_ON,
        ST_ISO_DN,
        ST_RST_DN,
        ST_SW_DN,
        ST_OFF,
        ST_SW_UP,
        ST_PG_WAIT,
        ST_RST_UP,
        ST_ISO_UP
    } pd_sw_state_e;

    localparam int DEF_N_STAGES   = 4;
    localparam int DEF_SW_DLY     = 8;
    localparam int DEF_ISO_DLY    = 4;
    localparam int DEF_PG_TIMEOUT = 255;

    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/dhm_pd_delay_cnt.sv
// Load/decrement down-counter shared by every timed wait of the controller.
// Holds at zero once expired; zero is flagged while the count is zero.
module dhm_pd_delay_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/dhm_pd_switch_ctrl.sv
// Power-domain responder: sequences isolation, domain reset and staged switch
// enables in answer to sleep, and returns sleep_ack once the domain is off.
module dhm_pd_switch_ctrl
    import dhm_pd_pkg::*;
#(
    parameter int N_STAGES   = DEF_N_STAGES,
    parameter int SW_DLY     = DEF_SW_DLY,
    parameter int ISO_DLY    = DEF_ISO_DLY,
    parameter int PG_TIMEOUT = DEF_PG_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sleep,
    output logic                sleep_ack,
    input  logic                pwr_good,
    output logic [N_STAGES-1:0] sw_en,
    output logic                iso_en,
    output logic                pd_rst_n,
    output logic                busy,
    output logic                pg_err,
    output pd_sw_state_e        dbg_state
);

    localparam int CW = cnt_width(SW_DLY, ISO_DLY, PG_TIMEOUT);
    // A wait of L cycles loads L-1 so the exit edge lands exactly L cycles after entry.
    localparam logic [CW-1:0] SW_LOAD  = CW'(SW_DLY - 1);
    localparam logic [CW-1:0] ISO_LOAD = CW'(ISO_DLY - 1);
    localparam logic [CW-1:0] PG_LOAD  = CW'(PG_TIMEOUT - 1);
    localparam logic [N_STAGES-1:0] ALL_ON = '1;
    localparam logic [N_STAGES-1:0] ONE    = N_STAGES'(1);

    pd_sw_state_e        state_q, state_d;
    logic [N_STAGES-1:0] sw_en_q, sw_en_d;
    logic                iso_en_q, iso_en_d;
    logic                pd_rst_n_q, pd_rst_n_d;
    logic                sleep_ack_q, sleep_ack_d;
    logic                busy_q, busy_d;
    logic                pg_err_q, pg_err_d;
    logic                pg_meta_q, pg_meta_d;
    logic                pg_sync_q, pg_sync_d;
    logic [N_STAGES-1:0] sw_up;
    logic                cnt_load;
    logic [CW-1:0]       cnt_val;
    logic                cnt_zero;

    dhm_pd_delay_cnt #(.W(CW)) u_delay_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    assign sw_up = (sw_en_q << 1) | ONE;

    always_comb begin
        state_d     = state_q;
        sw_en_d     = sw_en_q;
        iso_en_d    = iso_en_q;
        pd_rst_n_d  = pd_rst_n_q;
        sleep_ack_d = sleep_ack_q;
        pg_err_d    = pg_err_q;
        pg_meta_d   = pwr_good;
        pg_sync_d   = pg_meta_q;
        cnt_load    = 1'b0;
        cnt_val     = '0;
        case (state_q)
            ST_ON: begin
                if (sleep) begin
                    state_d  = ST_ISO_DN;
                    iso_en_d = 1'b1;
                    cnt_load = 1'b1;
                    cnt_val  = ISO_LOAD;
                end
            end
            ST_ISO_DN: begin
                if (cnt_zero) begin
                    state_d    = ST_RST_DN;
                    pd_rst_n_d = 1'b0;
                end
            end
            ST_RST_DN: begin
                state_d  = ST_SW_DN;
                sw_en_d  = sw_en_q >> 1;
                cnt_load = 1'b1;
                cnt_val  = SW_LOAD;
            end
            ST_SW_DN: begin
                if (cnt_zero) begin
                    if (sw_en_q == '0) begin
                        state_d     = ST_OFF;
                        sleep_ack_d = 1'b1;
                    end else begin
                        sw_en_d  = sw_en_q >> 1;
                        cnt_load = 1'b1;
                        cnt_val  = SW_LOAD;
                    end
                end
            end
            ST_OFF: begin
                if (!sleep) begin
                    state_d     = ST_SW_UP;
                    sleep_ack_d = 1'b0;
                    sw_en_d     = sw_up;
                    cnt_load    = 1'b1;
                    cnt_val     = SW_LOAD;
                end
            end
            ST_SW_UP: begin
                if (cnt_zero) begin
                    sw_en_d  = sw_up;
                    cnt_load = 1'b1;
                    if (sw_up == ALL_ON) begin
                        state_d = ST_PG_WAIT;
                        cnt_val = PG_LOAD;
                    end else begin
                        cnt_val = SW_LOAD;
                    end
                end
            end
            ST_PG_WAIT: begin
                // A sleep request here backs out through the switch ramp without touching reset.
                if (sleep) begin
                    state_d  = ST_SW_DN;
                    sw_en_d  = sw_en_q >> 1;
                    cnt_load = 1'b1;
                    cnt_val  = SW_LOAD;
                end else if (pg_sync_q) begin
                    state_d = ST_RST_UP;
                end else if (cnt_zero) begin
                    pg_err_d = 1'b1;
                end
            end
            ST_RST_UP: begin
                state_d    = ST_ISO_UP;
                pd_rst_n_d = 1'b1;
                cnt_load   = 1'b1;
                cnt_val    = ISO_LOAD;
            end
            ST_ISO_UP: begin
                if (cnt_zero) begin
                    state_d  = ST_ON;
                    iso_en_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_OFF;
                sw_en_d     = '0;
                iso_en_d    = 1'b1;
                pd_rst_n_d  = 1'b0;
                sleep_ack_d = 1'b1;
            end
        endcase
        busy_d = (state_d != ST_ON) && (state_d != ST_OFF);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_OFF;
            sw_en_q     <= '0;
            iso_en_q    <= 1'b1;
            pd_rst_n_q  <= 1'b0;
            sleep_ack_q <= 1'b1;
            busy_q      <= 1'b0;
            pg_err_q    <= 1'b0;
            pg_meta_q   <= 1'b0;
            pg_sync_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sw_en_q     <= sw_en_d;
            iso_en_q    <= iso_en_d;
            pd_rst_n_q  <= pd_rst_n_d;
            sleep_ack_q <= sleep_ack_d;
            busy_q      <= busy_d;
            pg_err_q    <= pg_err_d;
            pg_meta_q   <= pg_meta_d;
            pg_sync_q   <= pg_sync_d;
        end
    end

    assign sw_en     = sw_en_q;
    assign iso_en    = iso_en_q;
    assign pd_rst_n  = pd_rst_n_q;
    assign sleep_ack = sleep_ack_q;
    assign busy      = busy_q;
    assign pg_err    = pg_err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_dhm_pd_switch_ctrl.sv
// Bench for dhm_pd_switch_ctrl: vector table for the nominal up/down ramps,
// hand sequences for timeout, reversal and mid-ramp reset, then random soak.
module tb_dhm_pd_switch_ctrl;
    import dhm_pd_pkg::*;

    localparam int N   = 4;
    localparam int SW  = 8;
    localparam int ISO = 4;
    localparam int PGT = 255;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         sleep;
    logic         pwr_good;
    logic         sleep_ack;
    logic [N-1:0] sw_en;
    logic         iso_en;
    logic         pd_rst_n;
    logic         busy;
    logic         pg_err;
    pd_sw_state_e dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    dhm_pd_switch_ctrl #(
        .N_STAGES(N), .SW_DLY(SW), .ISO_DLY(ISO), .PG_TIMEOUT(PGT)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .sleep     (sleep),
        .sleep_ack (sleep_ack),
        .pwr_good  (pwr_good),
        .sw_en     (sw_en),
        .iso_en    (iso_en),
        .pd_rst_n  (pd_rst_n),
        .busy      (busy),
        .pg_err    (pg_err),
        .dbg_state (dbg_state)
    );

    // Output vector layout: {sleep_ack, sw_en[3:0], iso_en, pd_rst_n, busy, pg_err}
    function automatic logic [8:0] pk(input logic ack, input logic [N-1:0] sw, input logic iso,
                                      input logic rst, input logic bsy, input logic err);
        return {ack, sw, iso, rst, bsy, err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {sleep_ack, sw_en, iso_en, pd_rst_n, busy, pg_err};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: ack,sw,iso,rst,busy,err got %b expected %b", name, act, exp);
    endtask

    task automatic check_state(input string name, input pd_sw_state_e exp);
        n_checks++;
        if (dbg_state === exp) n_pass++;
        else $display("FAIL %s: state got %0d expected %0d", name, dbg_state, exp);
    endtask

    typedef struct {
        int         adv;
        logic       sl;
        logic       pg;
        logic [8:0] exp;
        string      name;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input string name, input logic sl, input logic pg, input int adv,
                       input logic [8:0] exp);
        vec_t v;
        v.adv = adv; v.sl = sl; v.pg = pg; v.exp = exp; v.name = name;
        tbl.push_back(v);
    endtask

    // Reference model: phase plus entry edge; outputs follow from elapsed cycles.
    typedef enum {M_OFF, M_UP, M_PG, M_RUP, M_ON, M_DN, M_SWDN} mmode_e;
    mmode_e m_mode;
    int     m_n;
    int     m_t;
    logic   m_err;
    logic   m_h0, m_h1;

    function automatic logic [N-1:0] thermo(input int st);
        logic [N-1:0] t;
        t = '0;
        for (int i = 0; i < N; i++) if (i < st) t[i] = 1'b1;
        return t;
    endfunction

    task automatic model_edge(input logic rn, input logic sl, input logic pg);
        logic sync;
        m_n++;
        if (!rn) begin
            m_mode = M_OFF; m_err = 1'b0; m_h0 = 1'b0; m_h1 = 1'b0;
        end else begin
            sync = m_h0; m_h0 = m_h1; m_h1 = pg;
            case (m_mode)
                M_OFF:  if (!sl) begin m_mode = M_UP; m_t = m_n; end
                M_UP:   if (m_n - m_t == (N - 1) * SW) begin m_mode = M_PG; m_t = m_n; end
                M_PG: begin
                    if (sl) begin m_mode = M_SWDN; m_t = m_n; end
                    else if (sync) begin m_mode = M_RUP; m_t = m_n; end
                    else if (m_n - m_t >= PGT) m_err = 1'b1;
                end
                M_RUP:  if (m_n - m_t == 1 + ISO) m_mode = M_ON;
                M_ON:   if (sl) begin m_mode = M_DN; m_t = m_n; end
                M_DN:   if (m_n - m_t == ISO + 1) begin m_mode = M_SWDN; m_t = m_n; end
                M_SWDN: if (m_n - m_t == N * SW) m_mode = M_OFF;
                default: m_mode = M_OFF;
            endcase
        end
    endtask

    function automatic logic [8:0] model_exp();
        int k;
        int st;
        k = m_n - m_t;
        case (m_mode)
            M_UP:   return pk(1'b0, thermo(1 + k / SW), 1'b1, 1'b0, 1'b1, m_err);
            M_PG:   return pk(1'b0, thermo(N), 1'b1, 1'b0, 1'b1, m_err);
            M_RUP:  return pk(1'b0, thermo(N), 1'b1, k >= 1, 1'b1, m_err);
            M_ON:   return pk(1'b0, thermo(N), 1'b0, 1'b1, 1'b0, m_err);
            M_DN:   return pk(1'b0, thermo(N), 1'b1, k < ISO, 1'b1, m_err);
            M_SWDN: begin
                st = N - 1 - k / SW;
                if (st < 0) st = 0;
                return pk(1'b0, thermo(st), 1'b1, 1'b0, 1'b1, m_err);
            end
            default: return pk(1'b1, '0, 1'b1, 1'b0, 1'b0, m_err);
        endcase
    endfunction

    initial begin
        int hold;
        reset_n  = 1'b0;
        sleep    = 1'b0;
        pwr_good = 1'b1;

        repeat (3) tick();
        check("reset", pk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
        check_state("reset_state", ST_OFF);
        reset_n = 1'b1;

        add("up_s1",     1'b0, 1'b1, 1, pk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0));
        add("up_s1_end", 1'b0, 1'b1, 7, pk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0));
        add("up_s2",     1'b0, 1'b1, 1, pk(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0));
        add("up_s3",     1'b0, 1'b1, 8, pk(1'b0, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0));
        add("up_s4",     1'b0, 1'b1, 8, pk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0));
        add("up_pgok",   1'b0, 1'b1, 1, pk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0));
        add("up_rstrel", 1'b0, 1'b1, 1, pk(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0));
        add("up_isohld", 1'b0, 1'b1, 3, pk(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0));
        add("up_on",     1'b0, 1'b1, 1, pk(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0));
        add("on_hold",   1'b0, 1'b1, 5, pk(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0));
        add("dn_iso",    1'b1, 1'b1, 1, pk(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0));
        add("dn_isohld", 1'b1, 1'b1, 3, pk(1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0));
        add("dn_rst",    1'b1, 1'b1, 1, pk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0));
        add("dn_s3",     1'b1, 1'b1, 1, pk(1'b0, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0));
        add("dn_s3_end", 1'b1, 1'b1, 7, pk(1'b0, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0));
        add("dn_s2",     1'b1, 1'b1, 1, pk(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b0));
        add("dn_s1",     1'b1, 1'b1, 8, pk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b0));
        add("dn_s0",     1'b1, 1'b1, 8, pk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0));
        add("dn_wait",   1'b1, 1'b1, 7, pk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0));
        add("dn_off",    1'b1, 1'b1, 1, pk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));
        add("off_hold",  1'b1, 1'b1, 10, pk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            sleep    = tbl[i].sl;
            pwr_good = tbl[i].pg;
            repeat (tbl[i].adv) tick();
            check(tbl[i].name, tbl[i].exp);
        end

        // pwr_good never arrives: error exactly PGT cycles after the last stage turns on.
        pwr_good = 1'b0;
        sleep    = 1'b0;
        repeat (24 + PGT) tick();
        check("pg_before_to", pk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0));
        tick();
        check("pg_timeout", pk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1));
        repeat (20) tick();
        check("pg_stay", pk(1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b1));
        check_state("pg_stay_state", ST_PG_WAIT);
        sleep = 1'b1;
        tick();
        check("pg_abort_s3", pk(1'b0, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b1));
        repeat (31) tick();
        check("pg_abort_s0", pk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1));
        tick();
        check("pg_abort_off", pk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1));

        // sleep reverses in the middle of the down ramp: down completes, then up restarts.
        sleep    = 1'b0;
        pwr_good = 1'b1;
        repeat (31) tick();
        check("rev_on", pk(1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1));
        sleep = 1'b1;
        repeat (10) tick();
        sleep = 1'b0;
        repeat (2) tick();
        sleep = 1'b1;
        repeat (3) tick();
        sleep = 1'b0;
        repeat (22) tick();
        check("rev_s0", pk(1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b1));
        tick();
        check("rev_off", pk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1));
        tick();
        check("rev_up", pk(1'b0, 4'b0001, 1'b1, 1'b0, 1'b1, 1'b1));

        // reset mid power-up ramp returns to the reset values and clears pg_err.
        repeat (8) tick();
        check("rst_mid_pre", pk(1'b0, 4'b0011, 1'b1, 1'b0, 1'b1, 1'b1));
        reset_n = 1'b0;
        tick();
        check("rst_mid", pk(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0));

        // Random soak against the reference model.
        m_mode = M_OFF; m_n = 0; m_t = 0; m_err = 1'b0; m_h0 = 1'b0; m_h1 = 1'b0;
        hold = 0;
        for (int c = 0; c < 6000; c++) begin
            reset_n = (c == 0) ? 1'b0 : ($urandom_range(0, 1499) != 0);
            if (hold == 0) begin
                sleep = ~sleep;
                hold  = ($urandom_range(0, 9) == 0) ? $urandom_range(300, 500) : $urandom_range(1, 100);
            end else begin
                hold--;
            end
            if (pwr_good) begin
                if ($urandom_range(0, 199) == 0) pwr_good = 1'b0;
            end else begin
                if ($urandom_range(0, 149) == 0) pwr_good = 1'b1;
            end
            @(posedge clk);
            model_edge(reset_n, sleep, pwr_good);
            #1;
            check("rand", model_exp());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
